// File: rtl/c3aibadapt_avmm_cmd_pkg.sv
// Shared constants for the AVMM command framer: legal lane/frame widths,
// decoded field positions inside a command frame and the beat-count helper.
package c3aibadapt_avmm_cmd_pkg;

    // Legal serial lane widths and frame widths
    localparam int LANE_W_LEGAL_0 = 2;
    localparam int LANE_W_LEGAL_1 = 4;
    localparam int LANE_W_LEGAL_2 = 8;
    localparam int FRAME_W_LEGAL_0 = 32;
    localparam int FRAME_W_LEGAL_1 = 64;

    // Field positions inside an assembled frame (bit 0 is the start marker)
    localparam int CMD_WRITE_BIT   = 1;
    localparam int CMD_REQUEST_BIT = 2;
    localparam int CMD_READ_BIT    = 3;
    localparam int CMD_ADDR_LSB    = 4;
    localparam int CMD_ADDR_MSB    = 13;
    localparam int CMD_ADDR_W      = CMD_ADDR_MSB - CMD_ADDR_LSB + 1;
    localparam int CMD_WDATA_W     = 8;

    // Beat counter width as exposed on the testbus
    localparam int CNT_W = 6;

    function automatic bit lane_w_is_legal(input int lane_w);
        return (lane_w == LANE_W_LEGAL_0) || (lane_w == LANE_W_LEGAL_1) ||
               (lane_w == LANE_W_LEGAL_2);
    endfunction

    function automatic bit frame_w_is_legal(input int frame_w, input int lane_w);
        return ((frame_w == FRAME_W_LEGAL_0) || (frame_w == FRAME_W_LEGAL_1)) &&
               ((frame_w % lane_w) == 0);
    endfunction

    // Number of serial beats that make up one frame
    function automatic int beat_count(input int frame_w, input int lane_w);
        return frame_w / lane_w;
    endfunction

endpackage

// File: rtl/c3aibadapt_avmm_cmdframer_if.sv
// Command output bus of the AVMM command framer: valid/ready handshake plus
// the held frame and its decoded fields.
interface c3aibadapt_avmm_cmdframer_if
    import c3aibadapt_avmm_cmd_pkg::*;
#(
    parameter int FRAME_W = 32
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [FRAME_W-1:0]     cmd_frame;
    logic                   cmd_write;
    logic                   cmd_request;
    logic                   cmd_read;
    logic [CMD_ADDR_W-1:0]  cmd_addr;
    logic [CMD_WDATA_W-1:0] cmd_writedata;

    modport master (
        output cmd_valid, cmd_frame, cmd_write, cmd_request, cmd_read,
               cmd_addr, cmd_writedata,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_frame, cmd_write, cmd_request, cmd_read,
               cmd_addr, cmd_writedata,
        output cmd_ready
    );
endinterface

// File: rtl/c3aibadapt_cmn_parity_checker.sv
// Even-parity checker: flags when the parity bit does not equal the XOR of
// the protected data bits. Only built when C3AIBADAPT_AVMM_CMDFRAMER_PARITY_EN
// is defined, since nothing else instantiates it.
`ifdef C3AIBADAPT_AVMM_CMDFRAMER_PARITY_EN
module c3aibadapt_cmn_parity_checker #(
    parameter int WIDTH = 31
) (
    input  logic [WIDTH-1:0] data,
    input  logic             par_bit,
    output logic             par_err
);
    assign par_err = par_bit ^ (^data);
endmodule
`endif

// File: rtl/c3aibadapt_avmm_cmdframer.sv
// AVMM serial command framer: assembles LANE_W-wide beats into FRAME_W-bit
// command frames, presents them on a valid/ready bus with decoded fields and
// keeps sticky framing/parity/overflow errors.
// Optional feature: define C3AIBADAPT_AVMM_CMDFRAMER_PARITY_EN to enable the
// even-parity check of frame bit PAR_POS (0 < PAR_POS < FRAME_W-1).
module c3aibadapt_avmm_cmdframer
    import c3aibadapt_avmm_cmd_pkg::*;
#(
    parameter int LANE_W  = 2,
    parameter int FRAME_W = 32,
    parameter int PAR_POS = 23
) (
    input  logic                 avmm_clock_rx_osc_clk,
    input  logic                 avmm_reset_rx_osc_clk_rst_n,
    input  logic [LANE_W-1:0]    aib_hssi_avmm_data_in,
    input  logic                 r_avmm_err_clr,
    c3aibadapt_avmm_cmdframer_if.master cmd_if,
    output logic                 err_framing,
    output logic                 err_parity,
    output logic                 err_overflow,
    output logic                 avmm_cmdframer_error,
    output logic [7:0]           avmm_cmdframer_testbus
);

    localparam int             BEATS     = beat_count(FRAME_W, LANE_W);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Set wins over clear so an event in the clearing cycle is never lost
    function automatic logic sticky_next(input logic q, input logic set, input logic clr);
        return set | (q & ~clr);
    endfunction

    logic [LANE_W-1:0]         beat_p0;
    logic [CNT_W-1:0]          beat_cnt;
    logic [FRAME_W-LANE_W-1:0] acc_p1;
    logic [FRAME_W-1:0]        frame_asm;
    logic [FRAME_W-1:0]        frame_p2;
    logic                      vld_p2;
    logic                      cmd_ready;
    logic                      start_beat;
    logic                      in_frame;
    logic                      frame_done;
    logic                      framing_evt;
    logic                      load;
    logic                      ovf_evt;

    assign cmd_ready = cmd_if.cmd_ready;

    // ---- stage p0: input beat register ----
    // Capture the serial beat; all framing decisions use this registered copy
    always_ff @(posedge avmm_clock_rx_osc_clk) begin
        if (!avmm_reset_rx_osc_clk_rst_n) beat_p0 <= '0;
        else                              beat_p0 <= aib_hssi_avmm_data_in;
    end

    assign start_beat  = (beat_cnt == '0) && beat_p0[0];
    assign in_frame    = (beat_cnt != '0);
    assign frame_done  = (beat_cnt == LAST_BEAT);
    assign framing_evt = (beat_cnt == '0) && !beat_p0[0] && (|beat_p0[LANE_W-1:1]);

    // Beat counter: 0 is idle, a start beat moves to 1, then counts blindly to the last beat
    always_ff @(posedge avmm_clock_rx_osc_clk) begin
        if (!avmm_reset_rx_osc_clk_rst_n) beat_cnt <= '0;
        else if (frame_done)              beat_cnt <= '0;
        else if (in_frame)                beat_cnt <= beat_cnt + CNT_W'(1);
        else if (start_beat)              beat_cnt <= CNT_W'(1);
    end

    // ---- stage p1: frame assembly ----
    // Right-shifting accumulator: after BEATS-1 beats, beat 0 sits in the LSBs
    always_ff @(posedge avmm_clock_rx_osc_clk) begin
        if (start_beat || (in_frame && !frame_done))
            acc_p1 <= {beat_p0, acc_p1[FRAME_W-LANE_W-1:LANE_W]};
    end

    // The final beat completes the frame directly from the input register
    assign frame_asm = {beat_p0, acc_p1};
    assign load      = frame_done && (!vld_p2 || cmd_ready);
    assign ovf_evt   = frame_done && vld_p2 && !cmd_ready;

    // ---- stage p2: output frame register ----
    // Load on completion unless a held frame is still unaccepted; clear on handshake
    always_ff @(posedge avmm_clock_rx_osc_clk) begin
        if (!avmm_reset_rx_osc_clk_rst_n) begin
            vld_p2   <= 1'b0;
            frame_p2 <= '0;
        end else if (load) begin
            vld_p2   <= 1'b1;
            frame_p2 <= frame_asm;
        end else if (vld_p2 && cmd_ready) begin
            vld_p2   <= 1'b0;
        end
    end

    assign cmd_if.cmd_valid     = vld_p2;
    assign cmd_if.cmd_frame     = frame_p2;
    assign cmd_if.cmd_write     = frame_p2[CMD_WRITE_BIT];
    assign cmd_if.cmd_request   = frame_p2[CMD_REQUEST_BIT];
    assign cmd_if.cmd_read      = frame_p2[CMD_READ_BIT];
    assign cmd_if.cmd_addr      = frame_p2[CMD_ADDR_MSB:CMD_ADDR_LSB];
    assign cmd_if.cmd_writedata = frame_p2[FRAME_W-1 -: CMD_WDATA_W];

    // Sticky framing and overflow flags
    always_ff @(posedge avmm_clock_rx_osc_clk) begin
        if (!avmm_reset_rx_osc_clk_rst_n) begin
            err_framing  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_framing  <= sticky_next(err_framing, framing_evt, r_avmm_err_clr);
            err_overflow <= sticky_next(err_overflow, ovf_evt, r_avmm_err_clr);
        end
    end

`ifdef C3AIBADAPT_AVMM_CMDFRAMER_PARITY_EN
    logic [FRAME_W-2:0] par_data;
    logic               par_mismatch;

    assign par_data = {frame_asm[FRAME_W-1:PAR_POS+1], frame_asm[PAR_POS-1:0]};

    c3aibadapt_cmn_parity_checker #(
        .WIDTH (FRAME_W - 1)
    ) u_parity_checker (
        .data    (par_data),
        .par_bit (frame_asm[PAR_POS]),
        .par_err (par_mismatch)
    );

    // Sticky parity flag, evaluated only for frames that are actually loaded
    always_ff @(posedge avmm_clock_rx_osc_clk) begin
        if (!avmm_reset_rx_osc_clk_rst_n) err_parity <= 1'b0;
        else err_parity <= sticky_next(err_parity, load & par_mismatch, r_avmm_err_clr);
    end
`else
    assign err_parity = 1'b0;
`endif

    assign avmm_cmdframer_error   = err_framing | err_parity | err_overflow;
    // Overflow-pending: a frame completing now would be dropped
    assign avmm_cmdframer_testbus = {vld_p2, vld_p2 & ~cmd_ready, beat_cnt};

endmodule

// File: tb/tb_c3aibadapt_avmm_cmdframer.sv
// Directed bench for c3aibadapt_avmm_cmdframer: a 2-bit/32-bit instance and
// an 8-bit/64-bit instance driven from one clock and reset.
module tb_c3aibadapt_avmm_cmdframer;

`ifdef C3AIBADAPT_AVMM_CMDFRAMER_PARITY_EN
    localparam logic PAR_EXP = 1'b1;
`else
    localparam logic PAR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        err_clr;
    logic [1:0]  din_a;
    logic [7:0]  din_b;

    logic        fr_a, par_a, ovf_a, err_a;
    logic [7:0]  tb_a;
    logic        fr_b, par_b, ovf_b, err_b;
    logic [7:0]  tb_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    c3aibadapt_avmm_cmdframer_if #(.FRAME_W(32)) if_a ();
    c3aibadapt_avmm_cmdframer_if #(.FRAME_W(64)) if_b ();

    c3aibadapt_avmm_cmdframer #(.LANE_W(2), .FRAME_W(32), .PAR_POS(23)) u_dut_a (
        .avmm_clock_rx_osc_clk       (clk),
        .avmm_reset_rx_osc_clk_rst_n (rst_n),
        .aib_hssi_avmm_data_in       (din_a),
        .r_avmm_err_clr              (err_clr),
        .cmd_if                      (if_a),
        .err_framing                 (fr_a),
        .err_parity                  (par_a),
        .err_overflow                (ovf_a),
        .avmm_cmdframer_error        (err_a),
        .avmm_cmdframer_testbus      (tb_a)
    );

    c3aibadapt_avmm_cmdframer #(.LANE_W(8), .FRAME_W(64), .PAR_POS(23)) u_dut_b (
        .avmm_clock_rx_osc_clk       (clk),
        .avmm_reset_rx_osc_clk_rst_n (rst_n),
        .aib_hssi_avmm_data_in       (din_b),
        .r_avmm_err_clr              (err_clr),
        .cmd_if                      (if_b),
        .err_framing                 (fr_b),
        .err_parity                  (par_b),
        .err_overflow                (ovf_b),
        .avmm_cmdframer_error        (err_b),
        .avmm_cmdframer_testbus      (tb_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send_a(input logic [31:0] f);
        for (int k = 0; k < 16; k++) begin
            din_a = f[k*2 +: 2];
            @(negedge clk);
        end
        din_a = 2'b00;
    endtask

    task automatic send_b(input logic [63:0] f);
        for (int k = 0; k < 8; k++) begin
            din_b = f[k*8 +: 8];
            @(negedge clk);
        end
        din_b = 8'h00;
    endtask

    initial begin
        logic [31:0] fa;
        fa             = 32'h1234_5671;
        rst_n          = 1'b0;
        err_clr        = 1'b0;
        din_a          = 2'b00;
        din_b          = 8'h00;
        if_a.cmd_ready = 1'b1;
        if_b.cmd_ready = 1'b1;
        repeat (3) step();

        // Reset state
        check_eq("rst_valid",   if_a.cmd_valid, 0);
        check_eq("rst_frame",   if_a.cmd_frame, 0);
        check_eq("rst_write",   if_a.cmd_write, 0);
        check_eq("rst_addr",    if_a.cmd_addr, 0);
        check_eq("rst_wdata",   if_a.cmd_writedata, 0);
        check_eq("rst_error",   err_a, 0);
        check_eq("rst_testbus", tb_a, 8'h00);
        check_eq("rst_b_frame", if_b.cmd_frame, 0);

        rst_n = 1'b1;

        // Good frame, ready high: valid two edges after the last beat
        send_a(32'h5A80_0037);
        check_eq("lat_e1_valid", if_a.cmd_valid, 0);
        step();
        check_eq("lat_e2_valid", if_a.cmd_valid, 1);
        check_eq("good_frame",   if_a.cmd_frame, 32'h5A80_0037);
        check_eq("good_write",   if_a.cmd_write, 1);
        check_eq("good_request", if_a.cmd_request, 1);
        check_eq("good_read",    if_a.cmd_read, 0);
        check_eq("good_addr",    if_a.cmd_addr, 10'h003);
        check_eq("good_wdata",   if_a.cmd_writedata, 8'h5A);
        check_eq("good_noerr",   err_a, 0);
        step();
        check_eq("good_valid_clr", if_a.cmd_valid, 0);

        // Bad parity frame
        send_a(32'h5A00_0037);
        step();
        check_eq("par_valid", if_a.cmd_valid, 1);
        check_eq("par_frame", if_a.cmd_frame, 32'h5A00_0037);
        check_eq("par_err",   par_a, PAR_EXP);
        check_eq("par_error", err_a, PAR_EXP);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("par_clr", par_a, 0);

        // Back-to-back frames with ready low: second is dropped
        if_a.cmd_ready = 1'b0;
        send_a(32'h5A80_0037);
        send_a(32'h1234_5671);
        step();
        check_eq("ovf_valid",   if_a.cmd_valid, 1);
        check_eq("ovf_held",    if_a.cmd_frame, 32'h5A80_0037);
        check_eq("ovf_flag",    ovf_a, 1);
        check_eq("ovf_error",   err_a, 1);
        check_eq("ovf_testbus", tb_a, 8'hC0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("ovf_clr",       ovf_a, 0);
        check_eq("ovf_still_vld", if_a.cmd_valid, 1);
        if_a.cmd_ready = 1'b1;
        step();
        check_eq("ovf_accept", if_a.cmd_valid, 0);

        // Idle beat 2'b10: framing error, set wins over a coincident clear
        din_a = 2'b10;
        step();
        din_a   = 2'b00;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("frm_flag",    fr_a, 1);
        check_eq("frm_testbus", tb_a, 8'h00);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("frm_clr", fr_a, 0);

        // Wide instance: 8 beats of 8 bits
        send_b(64'hC300_0000_0000_0327);
        check_eq("b_lat_e1", if_b.cmd_valid, 0);
        step();
        check_eq("b_valid", if_b.cmd_valid, 1);
        check_eq("b_frame", if_b.cmd_frame, 64'hC300_0000_0000_0327);
        check_eq("b_wdata", if_b.cmd_writedata, 8'hC3);
        check_eq("b_addr",  if_b.cmd_addr, 10'h032);
        check_eq("b_write", if_b.cmd_write, 1);
        check_eq("b_read",  if_b.cmd_read, 0);
        check_eq("b_error", err_b, 0);

        // Reset in the middle of a frame while a frame is held
        if_a.cmd_ready = 1'b0;
        send_a(32'h5A80_0037);
        step();
        check_eq("mid_held", if_a.cmd_valid, 1);
        for (int k = 0; k < 7; k++) begin
            din_a = fa[k*2 +: 2];
            step();
        end
        din_a = fa[15:14];
        rst_n = 1'b0;
        step();
        step();
        check_eq("mid_rst_valid",   if_a.cmd_valid, 0);
        check_eq("mid_rst_frame",   if_a.cmd_frame, 0);
        check_eq("mid_rst_wdata",   if_a.cmd_writedata, 0);
        check_eq("mid_rst_testbus", tb_a, 8'h00);
        rst_n          = 1'b1;
        if_a.cmd_ready = 1'b1;
        din_a          = 2'b00;
        step();
        send_a(32'h5A80_0037);
        step();
        check_eq("post_valid", if_a.cmd_valid, 1);
        check_eq("post_frame", if_a.cmd_frame, 32'h5A80_0037);
        check_eq("post_addr",  if_a.cmd_addr, 10'h003);
        check_eq("post_wdata", if_a.cmd_writedata, 8'h5A);
        check_eq("post_error", err_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
